usb_rx_nrzi_unstuff: RTL and testbench
======================================

Name: usb_rx_nrzi_unstuff

Overview:
Receive-path stage directly upstream of the SIPO shift register. Takes one sampled line state per bit time from the receive sampler and does four jobs:
- NRZI decode
- SYNC pattern detection
- Bit-unstuffing
- EOP detection

It drives the SIPO's serial_in/shift_enable inputs with one pulse per true data bit. It also flags packet boundaries and line errors to the packet layer.

Parameters:
SYNC_MIN_ZEROS, 5, minimum decoded zeros preceding the SYNC-terminating one (tolerates lost leading bits).
STUFF_LEN, 6, consecutive decoded ones after which a stuffed zero is mandatory.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous reset, active-high.
bit_strobe  input  1  one-cycle pulse per bit time; line_j/se0 valid in this cycle.
line_j  input  1  differential state, 1=J, 0=K; ignored when se0=1.
se0  input  1  single-ended zero (both lines low).
serial_in  output  1  decoded, unstuffed data bit (LSB-first wire order).
shift_enable  output  1  one-cycle pulse: serial_in valid, SIPO must shift.
pkt_active  output  1  high from SYNC detection until EOP/abort return to IDLE.
sync_found  output  1  one-cycle pulse on SYNC completion.
eop  output  1  one-cycle pulse on valid end-of-packet.
rx_err  output  1  one-cycle pulse on stuff violation or malformed EOP.

Behaviour:
- Clock and reset: single clock CLK; reset RST is synchronous, active-high.
- Reset values:
  - all outputs 0
  - state=IDLE
  - prev_level=J
  - ones_cnt=0
  - zero_cnt=0
- RST mid-packet: IDLE on the next edge; no eop/rx_err emitted.
- Sampling and latency:
  - Nothing changes on cycles without bit_strobe.
  - All outputs are registered, asserted the cycle after the strobe cycle.
  - Pulses last exactly one cycle.
- NRZI decode on a non-SE0 strobe:
  - d = 1 if line_j == prev_level, else 0.
  - prev_level <= line_j.
  - An SE0 strobe does not update prev_level.
  - Returning to IDLE forces prev_level=J.
- FSM states: IDLE, SYNC, DATA, EOP, ABORT.
- IDLE:
  - J strobe: stay.
  - SE0 strobe: stay.
  - K strobe: go to SYNC with zero_cnt=1.
- SYNC:
  - d=0: zero_cnt++ (saturate at 15).
  - d=1 with zero_cnt >= SYNC_MIN_ZEROS: go to DATA; pulse sync_found; set pkt_active; ones_cnt=1 (the SYNC's final one counts toward stuffing).
  - d=1 with zero_cnt < SYNC_MIN_ZEROS: go to IDLE silently.
  - SE0: go to IDLE silently.
- DATA, non-SE0 strobe:
  - ones_cnt == STUFF_LEN and d=0: stuffed bit, dropped; no shift_enable; ones_cnt=0.
  - ones_cnt == STUFF_LEN and d=1: pulse rx_err; go to ABORT.
  - Otherwise: shift_enable=1, serial_in=d; ones_cnt = d ? ones_cnt+1 : 0.
- DATA, SE0 strobe: go to EOP; no shift. A pending stuff at that point is not an error.
- EOP:
  - SE0 strobe: stay.
  - J strobe: pulse eop; clear pkt_active; go to IDLE.
  - K strobe: pulse rx_err; clear pkt_active; go to IDLE.
- ABORT:
  - Ignore data strobes.
  - Once an SE0 strobe is seen, the next J strobe goes to IDLE.
  - No eop pulse; pkt_active clears on entering IDLE.
- Simultaneous events: se0 has priority over line_j.
- pkt_active is held for the entire ABORT state.

Test Plan:
1. Idle line: 20 J strobes -> all outputs remain 0, state IDLE.
2. SYNC KJKJKJKK, then byte 0xA5 NRZI-encoded LSB-first, then SE0,SE0,J -> one sync_found pulse; 8 shift_enable pulses with serial_in = 1,0,1,0,0,1,0,1; one eop pulse; pkt_active returns 0 the cycle after the J strobe.
3. SYNC, then 0xFF with the stuffed bit inserted after the 5th data one (ones_cnt reaches 6), then EOP -> 9 data strobes; exactly 8 shift_enable pulses, all serial_in=1; no rx_err; eop pulse.
4. SYNC, then 6 decoded ones with no stuff (7th consecutive one including SYNC's), then SE0,J -> rx_err pulse one cycle after the offending strobe; no further shift_enable; no eop; IDLE after J.
5. Short SYNC KJKK (3 zeros, then a one) -> no sync_found, pkt_active stays 0; a following full SYNC + 1 byte is received normally.
6. RST high for one cycle after 4 data bits -> all outputs 0 next cycle; pkt_active 0; a subsequent full packet (test 2 stimulus) yields identical results to test 2.

Source files
------------

// File: rtl/usb_rx_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_nrzi_unstuff
// Description : USB receive front end sitting directly ahead of the SIPO.
//               - Decodes the NRZI line.
//               - Locks onto the SYNC pattern.
//               - Removes stuffed zeros, emitting one shift pulse per true
//                 data bit.
//               - Detects end-of-packet and flags line errors.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_nrzi_unstuff #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int STUFF_LEN      = 6
) (
    input  logic CLK,
    input  logic RST,
    input  logic bit_strobe,
    input  logic line_j,
    input  logic se0,
    output logic serial_in,
    output logic shift_enable,
    output logic pkt_active,
    output logic sync_found,
    output logic eop,
    output logic rx_err
);

    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    localparam logic [ONES_W-1:0] c_stuff_len = ONES_W'(STUFF_LEN);
    localparam logic [3:0]        c_sync_min  = 4'(SYNC_MIN_ZEROS);
    localparam logic [3:0]        c_zero_max  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_DATA  = 3'd2,
        S_EOP   = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_prev_level;
    logic [ONES_W-1:0]  r_ones_cnt;
    logic [3:0]         r_zero_cnt;
    logic               r_abort_se0;

    // NRZI: an unchanged line level is a one, a transition is a zero
    logic w_d;
    assign w_d = (line_j == r_prev_level);

    // Single registered FSM; every output is a register updated on strobes
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_prev_level <= 1'b1;
            r_ones_cnt   <= '0;
            r_zero_cnt   <= '0;
            r_abort_se0  <= 1'b0;
            serial_in    <= 1'b0;
            shift_enable <= 1'b0;
            pkt_active   <= 1'b0;
            sync_found   <= 1'b0;
            eop          <= 1'b0;
            rx_err       <= 1'b0;
        end else begin
            // Pulse outputs are one cycle wide by default
            shift_enable <= 1'b0;
            sync_found   <= 1'b0;
            eop          <= 1'b0;
            rx_err       <= 1'b0;

            if (bit_strobe) begin
                // SE0 carries no differential level, so the NRZI reference holds
                if (!se0) begin
                    r_prev_level <= line_j;
                end

                case (r_state)
                    S_IDLE: begin
                        if (!se0 && !line_j) begin
                            r_state    <= S_SYNC;
                            r_zero_cnt <= 4'd1;
                        end
                    end

                    S_SYNC: begin
                        if (se0) begin
                            r_state      <= S_IDLE;
                            r_prev_level <= 1'b1;
                        end else if (!w_d) begin
                            if (r_zero_cnt != c_zero_max) begin
                                r_zero_cnt <= r_zero_cnt + 4'd1;
                            end
                        end else if (r_zero_cnt >= c_sync_min) begin
                            // The SYNC's closing one starts the stuffing run
                            r_state    <= S_DATA;
                            sync_found <= 1'b1;
                            pkt_active <= 1'b1;
                            r_ones_cnt <= ONES_W'(1);
                        end else begin
                            r_state      <= S_IDLE;
                            r_prev_level <= 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (se0) begin
                            // A stuff bit still owed at EOP is legal
                            r_state <= S_EOP;
                        end else if (r_ones_cnt == c_stuff_len) begin
                            if (!w_d) begin
                                r_ones_cnt <= '0;
                            end else begin
                                rx_err      <= 1'b1;
                                r_state     <= S_ABORT;
                                r_abort_se0 <= 1'b0;
                            end
                        end else begin
                            shift_enable <= 1'b1;
                            serial_in    <= w_d;
                            r_ones_cnt   <= w_d ? (r_ones_cnt + ONES_W'(1)) : '0;
                        end
                    end

                    S_EOP: begin
                        if (!se0) begin
                            if (line_j) begin
                                eop <= 1'b1;
                            end else begin
                                rx_err <= 1'b1;
                            end
                            pkt_active   <= 1'b0;
                            r_state      <= S_IDLE;
                            r_prev_level <= 1'b1;
                        end
                    end

                    S_ABORT: begin
                        // Wait out the rest of the packet: SE0 then J
                        if (se0) begin
                            r_abort_se0 <= 1'b1;
                        end else if (line_j && r_abort_se0) begin
                            pkt_active   <= 1'b0;
                            r_state      <= S_IDLE;
                            r_prev_level <= 1'b1;
                            r_abort_se0  <= 1'b0;
                        end
                    end

                    default: begin
                        r_state      <= S_IDLE;
                        r_prev_level <= 1'b1;
                        pkt_active   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_nrzi_unstuff
// Description : Self-checking bench for usb_rx_nrzi_unstuff. Stimulus pushes
//               expected output events (with their due cycle) to a queue; a
//               monitor pops and compares whenever the DUT pulses an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_nrzi_unstuff;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic bit_strobe = 1'b0;
    logic line_j = 1'b1;
    logic se0 = 1'b0;
    logic serial_in, shift_enable, pkt_active, sync_found, eop, rx_err;

    usb_rx_nrzi_unstuff #(.SYNC_MIN_ZEROS(5), .STUFF_LEN(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bit_strobe   (bit_strobe),
        .line_j       (line_j),
        .se0          (se0),
        .serial_in    (serial_in),
        .shift_enable (shift_enable),
        .pkt_active   (pkt_active),
        .sync_found   (sync_found),
        .eop          (eop),
        .rx_err       (rx_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    localparam int EV_NONE = -1;
    localparam int EV_D0   = 0;
    localparam int EV_D1   = 1;
    localparam int EV_SYNC = 2;
    localparam int EV_EOP  = 3;
    localparam int EV_ERR  = 4;

    typedef struct {
        int code;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   mon_n;
    int   mon_code;
    logic tb_level = 1'b1;

    // Monitor: every output pulse must match the head of the expectation queue
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event actual=none required=code%0d@cyc%0d", e.code, e.at);
        end
        mon_n = int'(shift_enable) + int'(sync_found) + int'(eop) + int'(rx_err);
        if (mon_n > 1) begin
            checks++;
            failures++;
            $display("FAIL multi_pulse actual=%0d pulses required=1 at cyc %0d", mon_n, cyc);
        end else if (mon_n == 1) begin
            mon_code = shift_enable ? (serial_in ? EV_D1 : EV_D0) :
                       sync_found   ? EV_SYNC :
                       eop          ? EV_EOP  : EV_ERR;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=code%0d@cyc%0d required=none", mon_code, cyc);
            end else begin
                e = q.pop_front();
                if (e.code != mon_code || e.at != cyc) begin
                    failures++;
                    $display("FAIL event actual=code%0d@cyc%0d required=code%0d@cyc%0d",
                             mon_code, cyc, e.code, e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    // One strobe; returns at the negedge where its registered result is visible
    task automatic drive(input logic se0_v, input logic lvl, input int ev);
        @(negedge CLK);
        bit_strobe = 1'b1;
        se0        = se0_v;
        line_j     = lvl;
        if (ev != EV_NONE) q.push_back('{code: ev, at: cyc + 1});
        @(negedge CLK);
        bit_strobe = 1'b0;
        se0        = 1'b0;
    endtask

    task automatic nrzi_bit(input logic d, input int ev);
        if (!d) tb_level = ~tb_level;
        drive(1'b0, tb_level, ev);
    endtask

    task automatic send_j(input int ev);
        tb_level = 1'b1;
        drive(1'b0, 1'b1, ev);
    endtask

    task automatic send_k(input int ev);
        tb_level = 1'b0;
        drive(1'b0, 1'b0, ev);
    endtask

    task automatic send_se0();
        drive(1'b1, 1'b0, EV_NONE);
    endtask

    // KJKJKJKK starting from idle J
    task automatic send_sync();
        tb_level = 1'b1;
        for (int i = 0; i < 7; i++) nrzi_bit(1'b0, EV_NONE);
        nrzi_bit(1'b1, EV_SYNC);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) nrzi_bit(b[i], b[i] ? EV_D1 : EV_D0);
    endtask

    task automatic send_eop_good();
        send_se0();
        send_se0();
        check("pkt_active_in_eop", {7'd0, pkt_active}, 8'd1);
        send_j(EV_EOP);
        check("pkt_active_after_eop", {7'd0, pkt_active}, 8'd0);
    endtask

    task automatic test2_packet();
        send_sync();
        check("pkt_active_after_sync", {7'd0, pkt_active}, 8'd1);
        send_byte(8'hA5);
        send_eop_good();
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_outputs",
              {2'b0, serial_in, shift_enable, pkt_active, sync_found, eop, rx_err}, 8'h00);
        RST = 1'b0;

        // 1: idle line, with a couple of SE0 strobes mixed in
        send_se0();
        send_se0();
        for (int i = 0; i < 20; i++) send_j(EV_NONE);
        check("idle_pkt_active", {7'd0, pkt_active}, 8'd0);

        // 2: SYNC + 0xA5 + EOP
        test2_packet();

        // 3: 0xFF with a stuffed zero after the fifth data one
        send_sync();
        for (int i = 0; i < 5; i++) nrzi_bit(1'b1, EV_D1);
        nrzi_bit(1'b0, EV_NONE);
        for (int i = 0; i < 3; i++) nrzi_bit(1'b1, EV_D1);
        send_eop_good();

        // 4: missing stuff bit -> error, then abort until SE0,J
        send_sync();
        for (int i = 0; i < 5; i++) nrzi_bit(1'b1, EV_D1);
        nrzi_bit(1'b1, EV_ERR);
        check("pkt_active_abort", {7'd0, pkt_active}, 8'd1);
        send_j(EV_NONE);
        check("abort_j_before_se0", {7'd0, pkt_active}, 8'd1);
        send_k(EV_NONE);
        send_se0();
        check("abort_after_se0", {7'd0, pkt_active}, 8'd1);
        send_j(EV_NONE);
        check("abort_to_idle", {7'd0, pkt_active}, 8'd0);

        // 5: short SYNC rejected, then a normal packet
        tb_level = 1'b1;
        nrzi_bit(1'b0, EV_NONE);
        nrzi_bit(1'b0, EV_NONE);
        nrzi_bit(1'b0, EV_NONE);
        nrzi_bit(1'b1, EV_NONE);
        check("short_sync_pkt_active", {7'd0, pkt_active}, 8'd0);
        send_sync();
        send_byte(8'h3C);
        send_eop_good();

        // Pending stuff at SE0 is not an error
        send_sync();
        for (int i = 0; i < 5; i++) nrzi_bit(1'b1, EV_D1);
        send_eop_good();

        // Malformed EOP: SE0 followed by K
        send_sync();
        send_byte(8'h81);
        send_se0();
        send_k(EV_ERR);
        check("bad_eop_pkt_active", {7'd0, pkt_active}, 8'd0);

        // 6: reset mid-packet after 4 data bits
        send_sync();
        nrzi_bit(1'b1, EV_D1);
        nrzi_bit(1'b0, EV_D0);
        nrzi_bit(1'b1, EV_D1);
        nrzi_bit(1'b1, EV_D1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midpkt_reset_outputs",
              {2'b0, serial_in, shift_enable, pkt_active, sync_found, eop, rx_err}, 8'h00);
        test2_packet();

        repeat (4) @(negedge CLK);
        check("queue_drained", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
